regfile_cmd_ctrl: RTL and testbench

Command front-end that drives the system register file from a UART byte stream. It decodes write commands (0xAA, address, data) and read commands (0xBB, address), and issues the matching WrEn/RdEn transactions on the register-file port. It captures the read data and hands it to the UART transmitter with a single-cycle valid strobe. It sits between the UART RX data-sync output, the register file, and the UART TX input.

---
 rtl/regfile_cmd_ctrl.sv | 138 +++++++++++++
 tb/tb_regfile_cmd_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_cmd_ctrl.sv
// UART command front-end: decodes write (0xAA, addr, data) and read (0xBB, addr)
// byte sequences into register-file strobes and returns read data to the UART TX.
module regfile_cmd_ctrl #(
  parameter int unsigned Data_bus_width    = 8,
  parameter int unsigned Address_bus_width = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [Data_bus_width-1:0]    RX_P_DATA,
  input  logic                         RX_D_VLD,
  input  logic [Data_bus_width-1:0]    RdData,
  input  logic                         TX_Busy,
  output logic [Address_bus_width-1:0] Address,
  output logic [Data_bus_width-1:0]    WrData,
  output logic                         WrEn,
  output logic                         RdEn,
  output logic [Data_bus_width-1:0]    TX_P_DATA,
  output logic                         TX_D_VLD
);

  localparam int unsigned DW = Data_bus_width;
  localparam int unsigned AW = Address_bus_width;

  localparam logic [DW-1:0] WR_CMD = DW'(8'hAA);
  localparam logic [DW-1:0] RD_CMD = DW'(8'hBB);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    RD_CAPT,
    TX_SEND
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [AW-1:0]   address_q, address_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic            wr_en_q, wr_en_d;
  logic            rd_en_q, rd_en_d;
  logic [DW-1:0]   tx_data_q, tx_data_d;
  logic            tx_vld_q, tx_vld_d;

  // State and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      address_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      address_q <= address_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
    end
  end

  // Next-state and next-output decode; strobes default low, data holds
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    address_d = address_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    tx_vld_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WR_CMD) begin
            state_d = WR_ADDR;
          end else if (RX_P_DATA == RD_CMD) begin
            state_d = RD_ADDR;
          end
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          wr_addr_d = RX_P_DATA[AW-1:0];
          state_d   = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          address_d = wr_addr_q;
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          address_d = RX_P_DATA[AW-1:0];
          rd_en_d   = 1'b1;
          state_d   = RD_WAIT;
        end
      end
      // Register file presents RdData on the edge closing this cycle
      RD_WAIT: begin
        state_d = RD_CAPT;
      end
      RD_CAPT: begin
        tx_data_d = RdData;
        state_d   = TX_SEND;
      end
      TX_SEND: begin
        if (!TX_Busy) begin
          tx_vld_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Address   = address_q;
  assign WrData    = wr_data_q;
  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Bench for regfile_cmd_ctrl: register-file stand-in, transaction-level reference
// model compared every cycle, and directed command sequences with literal checks.
module tb_regfile_cmd_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] RX_P_DATA = 8'h00;
  logic       RX_D_VLD = 1'b0;
  logic [7:0] RdData;
  logic       TX_Busy = 1'b0;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic       WrEn;
  logic       RdEn;
  logic [7:0] TX_P_DATA;
  logic       TX_D_VLD;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int tx_cnt = 0;

  regfile_cmd_ctrl #(.Data_bus_width(8), .Address_bus_width(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_P_DATA (RX_P_DATA),
    .RX_D_VLD  (RX_D_VLD),
    .RdData    (RdData),
    .TX_Busy   (TX_Busy),
    .Address   (Address),
    .WrData    (WrData),
    .WrEn      (WrEn),
    .RdEn      (RdEn),
    .TX_P_DATA (TX_P_DATA),
    .TX_D_VLD  (TX_D_VLD)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Register-file stand-in: preloaded with i*0x11, one-cycle read latency
  logic [7:0] rf [16];
  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 8'(i * 17);
    forever begin
      @(posedge CLK);
      if (WrEn) rf[Address] <= WrData;
      if (RdEn) RdData <= rf[Address];
    end
  end

  // Reference model: collects bytes into a command packet, times read replies
  logic [7:0] mdl_mem [16];
  logic [7:0] pkt [$];
  logic [7:0] b1;
  logic       rd_act = 1'b0;
  int         rd_age = 0;
  logic [3:0] raddr = 4'h0;
  logic [3:0] e_addr = 4'h0;
  logic [7:0] e_wd = 8'h00;
  logic [7:0] e_txd = 8'h00;
  logic       e_we = 1'b0;
  logic       e_re = 1'b0;
  logic       e_txv = 1'b0;

  initial begin
    for (int i = 0; i < 16; i++) mdl_mem[i] = 8'(i * 17);
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) begin
        e_addr = 4'h0; e_wd = 8'h00; e_txd = 8'h00;
        e_we = 1'b0; e_re = 1'b0; e_txv = 1'b0;
        rd_act = 1'b0;
        pkt.delete();
      end else begin
        e_we = 1'b0; e_re = 1'b0; e_txv = 1'b0;
        if (rd_act) begin
          if (rd_age == 1) e_txd = mdl_mem[raddr];
          if (rd_age >= 2 && !TX_Busy) begin
            e_txv  = 1'b1;
            rd_act = 1'b0;
          end
          rd_age++;
        end else if (RX_D_VLD) begin
          pkt.push_back(RX_P_DATA);
          if (pkt[0] != 8'hAA && pkt[0] != 8'hBB) begin
            pkt.delete();
          end else if (pkt[0] == 8'hAA && pkt.size() == 3) begin
            b1 = pkt[1];
            e_we = 1'b1;
            e_addr = b1[3:0];
            e_wd = pkt[2];
            mdl_mem[e_addr] = pkt[2];
            pkt.delete();
          end else if (pkt[0] == 8'hBB && pkt.size() == 2) begin
            b1 = pkt[1];
            e_re = 1'b1;
            e_addr = b1[3:0];
            raddr = b1[3:0];
            rd_act = 1'b1;
            rd_age = 0;
            pkt.delete();
          end
        end
      end
    end
  end

  // Every-cycle compare against the model, sampled on the falling edge
  initial begin
    forever begin
      @(negedge CLK);
      chk("WrEn", 32'(WrEn), 32'(e_we));
      chk("RdEn", 32'(RdEn), 32'(e_re));
      chk("TX_D_VLD", 32'(TX_D_VLD), 32'(e_txv));
      chk("Address", 32'(Address), 32'(e_addr));
      chk("WrData", 32'(WrData), 32'(e_wd));
      chk("TX_P_DATA", 32'(TX_P_DATA), 32'(e_txd));
      if (WrEn === 1'b1) wr_cnt++;
      if (RdEn === 1'b1) rd_cnt++;
      if (TX_D_VLD === 1'b1) tx_cnt++;
    end
  end

  // Called at posedge+1; presents one byte for one cycle
  task automatic send(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(posedge CLK); #1;
    RX_D_VLD  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  int c0;

  initial begin
    idle(3);
    RST = 1'b0;
    chk("rst_addr", 32'(Address), 32'h0);
    chk("rst_wren", 32'(WrEn), 32'h0);
    chk("rst_txd", 32'(TX_P_DATA), 32'h0);
    chk("rst_txv", 32'(TX_D_VLD), 32'h0);
    idle(1);

    // Write 0x5C to reg 3
    send(8'hAA); send(8'h03); send(8'h5C);
    chk("wr_en", 32'(WrEn), 32'h1);
    chk("wr_addr", 32'(Address), 32'h3);
    chk("wr_data", 32'(WrData), 32'h5C);
    idle(2);
    chk("wr_no_rd", 32'(rd_cnt), 32'h0);
    chk("wr_no_tx", 32'(tx_cnt), 32'h0);
    chk("mdl_mem3", 32'(mdl_mem[3]), 32'h5C);

    // Read reg 3 with TX idle: RdEn at n+1, TX_D_VLD at n+4
    send(8'hBB); send(8'h03);
    chk("rd_en", 32'(RdEn), 32'h1);
    chk("rd_addr", 32'(Address), 32'h3);
    idle(2);
    chk("rd_txv_n3", 32'(TX_D_VLD), 32'h0);
    chk("rd_txd_n3", 32'(TX_P_DATA), 32'h5C);
    idle(1);
    chk("rd_txv_n4", 32'(TX_D_VLD), 32'h1);
    idle(2);

    // Read with backpressure from RD_CAPT onward
    c0 = tx_cnt;
    send(8'hBB); send(8'h03);
    idle(1);
    TX_Busy = 1'b1;
    idle(10);
    chk("bp_held", 32'(tx_cnt - c0), 32'h0);
    TX_Busy = 1'b0;
    idle(1);
    chk("bp_txv", 32'(TX_D_VLD), 32'h1);
    chk("bp_txd", 32'(TX_P_DATA), 32'h5C);
    idle(2);
    chk("bp_once", 32'(tx_cnt - c0), 32'h1);

    // Garbage bytes then write with upper address nibble dropped
    send(8'h11); send(8'hFF); send(8'hAA); send(8'hF7); send(8'hA5);
    chk("tr_en", 32'(WrEn), 32'h1);
    chk("tr_addr", 32'(Address), 32'h7);
    chk("tr_data", 32'(WrData), 32'hA5);
    idle(2);

    // 0xAA during RD_WAIT is dropped; reg 2 holds its preload 0x22
    c0 = wr_cnt;
    send(8'hBB); send(8'h02); send(8'hAA);
    idle(2);
    chk("drop_txv", 32'(TX_D_VLD), 32'h1);
    chk("drop_txd", 32'(TX_P_DATA), 32'h22);
    idle(1);
    send(8'hAA); send(8'h01); send(8'h00);
    chk("drop_wren", 32'(WrEn), 32'h1);
    chk("drop_waddr", 32'(Address), 32'h1);
    chk("drop_wdata", 32'(WrData), 32'h00);
    idle(2);
    chk("drop_wcnt", 32'(wr_cnt - c0), 32'h1);

    // Reset during a partial write, then a stray byte
    c0 = wr_cnt;
    send(8'hAA); send(8'h04);
    RST = 1'b1;
    idle(2);
    RST = 1'b0;
    send(8'h77);
    idle(3);
    chk("rstm_nowr", 32'(wr_cnt - c0), 32'h0);
    chk("rstm_addr", 32'(Address), 32'h0);
    chk("rstm_wdata", 32'(WrData), 32'h0);
    chk("rstm_txd", 32'(TX_P_DATA), 32'h0);
    send(8'hAA); send(8'h05); send(8'h33);
    chk("rstm_wren", 32'(WrEn), 32'h1);
    chk("rstm_waddr", 32'(Address), 32'h5);
    chk("rstm_wdata2", 32'(WrData), 32'h33);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
